// File: rtl/qerv_pkg.sv
// rtl/qerv_pkg.sv - shared types and lane/nibble constants for the qerv sequencer
package qerv_pkg;

    localparam int DEF_LANE_W = 4;
    localparam int NIBBLES    = 32 / DEF_LANE_W;
    localparam int CNT_MAX    = NIBBLES - 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT_RF = 3'd2,
        ST_RUN1    = 3'd3,
        ST_MEM     = 3'd4,
        ST_RUN2    = 3'd5
    } state_e;

endpackage

// File: rtl/qerv_nibble_cnt.sv
// rtl/qerv_nibble_cnt.sv - wraparound nibble counter with enable, clear and pause
module qerv_nibble_cnt #(
    parameter int CNT_W   = 3,
    parameter int CNT_MAX = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_pause,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_adv,
    output logic             o_first,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_adv   = i_en & ~i_pause;
    assign o_first = o_adv & (cnt_q == '0);
    assign o_last  = o_adv & (cnt_q == MAX);
    assign o_cnt   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (o_adv) begin
            cnt_d = o_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qerv_cnt_sched.sv
// rtl/qerv_cnt_sched.sv - fetch / serial-pass / dbus sequencer for the nibble-serial qerv datapath
// Optional build macro QERV_CNT_PAUSE_EN adds i_pause to stall a pass in place.
module qerv_cnt_sched
    import qerv_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W,
    parameter int CNT_W  = $clog2(32 / LANE_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
`ifdef QERV_CNT_PAUSE_EN
    input  logic             i_pause,
`endif
    output logic             o_ibus_cyc,
    input  logic             i_ibus_ack,
    output logic             o_wb_en,
    input  logic             i_two_pass,
    input  logic             i_mem_op,
    output logic             o_dbus_cyc,
    input  logic             i_dbus_ack,
    input  logic             i_rf_ready,
    output logic             o_cnt_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt0,
    output logic             o_cnt_done,
    output logic             o_pass2,
    output logic             o_busy
);

    localparam int NIB = 32 / LANE_W;

    state_e           state_q, state_d;
    logic             two_pass_q, mem_op_q, dec_pend_q;
    logic             pause, run;
    logic             cnt_adv, cnt_first, cnt_last;
    logic [CNT_W-1:0] cnt;

`ifdef QERV_CNT_PAUSE_EN
    assign pause = i_pause;
`else
    assign pause = 1'b0;
`endif

    assign run = (state_q == ST_RUN1) || (state_q == ST_RUN2);

    qerv_nibble_cnt #(
        .CNT_W   (CNT_W),
        .CNT_MAX (NIB - 1)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (run),
        .i_clr   (~run),
        .i_pause (pause),
        .o_cnt   (cnt),
        .o_adv   (cnt_adv),
        .o_first (cnt_first),
        .o_last  (cnt_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode registers settle one cycle after the load strobe, so sample the op class then.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dec_pend_q <= 1'b0;
            two_pass_q <= 1'b0;
            mem_op_q   <= 1'b0;
        end else begin
            dec_pend_q <= o_wb_en;
            if (dec_pend_q) begin
                two_pass_q <= i_two_pass;
                mem_op_q   <= i_mem_op;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = ST_FETCH;
            ST_FETCH:   if (i_ibus_ack) state_d = ST_WAIT_RF;
            ST_WAIT_RF: if (i_rf_ready) state_d = ST_RUN1;
            ST_RUN1: begin
                if (cnt_last) begin
                    if (!two_pass_q) state_d = ST_FETCH;
                    else if (mem_op_q) state_d = ST_MEM;
                    else state_d = ST_RUN2;
                end
            end
            ST_MEM:     if (i_dbus_ack) state_d = ST_RUN2;
            ST_RUN2:    if (cnt_last) state_d = ST_FETCH;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ibus_cyc = (state_q == ST_FETCH);
        o_wb_en    = o_ibus_cyc & i_ibus_ack;
        o_dbus_cyc = (state_q == ST_MEM);
        o_pass2    = (state_q == ST_RUN2);
        o_busy     = (state_q != ST_IDLE);
        o_cnt_en   = cnt_adv;
        o_cnt      = cnt;
        o_cnt0     = cnt_first;
        o_cnt_done = cnt_last;
    end

endmodule
